vga_frame_sequencer: RTL
========================

VGA_FRAME_SEQUENCER -- requirements
Module: vga_frame_sequencer

Interface
REQ-001 SHALL have parameter FRAMES, 6, number of 16-word frames stored back-to-back in ROM (1..8).
REQ-002 SHALL have parameter TICKS_1MS, 25000, vga_clk cycles per millisecond.
REQ-003 SHALL have port vga_clk  input  1  single clock; all logic rising-edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port enable  input  1  run when high, pause when low.
REQ-006 SHALL have port dwell_ms  input  10  display time per frame in ms.
REQ-007 SHALL have port vblank  input  1  high during vertical blanking from the VGA timing block.
REQ-008 SHALL have port rom_addr  output  7  ROM read address.
REQ-009 SHALL have port rom_data  input  16  ROM read data, valid one cycle after rom_addr.
REQ-010 SHALL have port write_en  output  1  display-RAM write strobe.
REQ-011 SHALL have port write_addr  output  4  display-RAM row address.
REQ-012 SHALL have port write_data  output  16  display-RAM row data.
REQ-013 SHALL have port frame_idx  output  3  index of the frame currently loaded or displayed.
REQ-014 SHALL have port frame_done  output  1  one-cycle pulse when a frame's dwell ends.

Function
REQ-015 SHALL implement states IDLE, WAIT_VB, LOAD, DWELL.
REQ-016 IDLE SHALL go to WAIT_VB when enable=1 and SHALL otherwise hold.
REQ-017 WAIT_VB SHALL go to LOAD on the next cycle, subject to REQ-031.
REQ-018 LOAD SHALL issue rom_addr = frame_idx*16 + w for w = 0..15 on 16 consecutive cycles.
REQ-019 Writes SHALL lag the ROM address by exactly 1 cycle: write_en=1, write_addr=w and write_data=rom_data follow the cycle that issued address w.
REQ-020 LOAD SHALL therefore last 17 cycles and produce exactly 16 writes, rows 0..15 in order with no gaps.
REQ-021 write_en SHALL be 0 in every state except the 16 write cycles of LOAD.
REQ-022 LOAD SHALL always complete once started; enable=0 SHALL NOT truncate a frame.
REQ-023 On entry to DWELL, dwell_ms SHALL be sampled; a sampled value of 0 SHALL be treated as 1.
REQ-024 DWELL SHALL last sampled_ms*TICKS_1MS enabled cycles, using a ms sub-counter and a ms counter; dwell_ms changes during DWELL SHALL be ignored.
REQ-025 While enable=0 in DWELL, both counters SHALL freeze; counting SHALL resume where it stopped when enable returns to 1.
REQ-026 At dwell end the block SHALL pulse frame_done for 1 cycle and increment frame_idx, wrapping FRAMES-1 -> 0.
REQ-027 After dwell end the block SHALL go to WAIT_VB if enable=1, else to IDLE.
REQ-028 rom_addr SHALL hold its last value outside LOAD; frame_idx SHALL change only at dwell end.

Reset
REQ-029 rst_n low SHALL asynchronously force: state IDLE, rom_addr 0, write_en 0, write_addr 0, write_data 0, frame_idx 0, frame_done 0, counters 0.
REQ-030 Reset asserted mid-LOAD or mid-DWELL SHALL abort immediately; after release the sequence SHALL restart at frame 0 row 0.

Configuration
REQ-031 With VBLANK_SYNC_EN defined, WAIT_VB SHALL hold until vblank=1 and enter LOAD on the cycle after vblank is sampled high.
REQ-032 Without VBLANK_SYNC_EN, WAIT_VB SHALL advance unconditionally after 1 cycle and vblank SHALL be ignored.

Verification
Each scenario below SHALL be covered by the bench. All use TICKS_1MS=4 and FRAMES=6, with ROM word n = 16'hA000+n.
REQ-033 Reset, enable=1, dwell_ms=2 -> 16 writes, rows 0..15, data A000..A00F; then 8 idle cycles; then frame_done pulses with frame_idx 0->1.
REQ-034 Run 6 frames -> the 6th frame_done wraps frame_idx 5->0, and the next load reads rom_addr 0..15.
REQ-035 enable=0 for 10 cycles at DWELL cycle 3 -> frame_done arrives exactly 10 cycles late; enable=0 during LOAD -> all 16 writes still occur.
REQ-036 dwell_ms=0 -> dwell lasts 4 cycles; dwell_ms changed 2->5 mid-DWELL -> the current dwell stays 8 cycles.
REQ-037 rst_n pulsed low at LOAD write 7 -> write_en drops asynchronously; after release the next writes restart at row 0 with data A000.
REQ-038 With VBLANK_SYNC_EN defined, hold vblank=0 for 50 cycles -> no writes occur; raise vblank -> writes start 2 cycles later.

Source files
------------

// File: rtl/vga_frame_sequencer.sv
// Copies 16-word frames from ROM into display RAM, then holds each for dwell_ms ms.
// Optional: define VBLANK_SYNC_EN to start each load only after vblank is seen high.
module vga_frame_sequencer #(
  parameter int FRAMES    = 6,
  parameter int TICKS_1MS = 25000
) (
  input  logic        vga_clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [9:0]  dwell_ms,
  input  logic        vblank,
  output logic [6:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        write_en,
  output logic [3:0]  write_addr,
  output logic [15:0] write_data,
  output logic [2:0]  frame_idx,
  output logic        frame_done
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_VB = 2'd1;
  localparam logic [1:0] S_LOAD    = 2'd2;
  localparam logic [1:0] S_DWELL   = 2'd3;

  localparam int              SUB_W      = (TICKS_1MS > 1) ? $clog2(TICKS_1MS) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(TICKS_1MS - 1);
  localparam logic [2:0]      LAST_FRAME = 3'(FRAMES - 1);

  logic [1:0]       r_state;
  logic [4:0]       r_cnt;
  logic [SUB_W-1:0] r_sub;
  logic [9:0]       r_ms;
  logic [9:0]       r_ms_last;
  logic [6:0]       r_rom_addr;
  logic             r_we;
  logic [3:0]       r_waddr;
  logic [2:0]       r_frame;
  logic             r_done;
  logic             w_vb_go;
  logic [9:0]       w_ms_last;

`ifdef VBLANK_SYNC_EN
  assign w_vb_go = vblank;
`else
  logic w_vblank_unused;
  assign w_vblank_unused = vblank;
  assign w_vb_go = 1'b1;
`endif

  // A requested dwell of 0 ms behaves as 1 ms.
  assign w_ms_last = (dwell_ms == 10'd0) ? 10'd0 : dwell_ms - 10'd1;

  always_ff @(posedge vga_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_sub      <= '0;
      r_ms       <= '0;
      r_ms_last  <= '0;
      r_rom_addr <= '0;
      r_we       <= 1'b0;
      r_waddr    <= '0;
      r_frame    <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      // r_cnt runs 1..17 over the load; cycles with r_cnt<=16 have an address in flight.
      r_we    <= (r_state == S_LOAD) && (r_cnt <= 5'd16);
      r_waddr <= r_rom_addr[3:0];
      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_WAIT_VB;
        end
        S_WAIT_VB: begin
          if (w_vb_go) begin
            r_state    <= S_LOAD;
            r_rom_addr <= {r_frame, 4'd0};
            r_cnt      <= 5'd1;
          end
        end
        S_LOAD: begin
          if (r_cnt == 5'd17) begin
            r_state   <= S_DWELL;
            r_sub     <= '0;
            r_ms      <= '0;
            r_ms_last <= w_ms_last;
          end else begin
            if (r_cnt < 5'd16) r_rom_addr <= {r_frame, r_cnt[3:0]};
            r_cnt <= r_cnt + 5'd1;
          end
        end
        S_DWELL: begin
          if (enable) begin
            if (r_sub == SUB_LAST) begin
              r_sub <= '0;
              if (r_ms == r_ms_last) begin
                // Counting only advances while enabled, so the exit is always to WAIT_VB.
                r_state <= S_WAIT_VB;
                r_ms    <= '0;
                r_done  <= 1'b1;
                r_frame <= (r_frame == LAST_FRAME) ? 3'd0 : r_frame + 3'd1;
              end else begin
                r_ms <= r_ms + 10'd1;
              end
            end else begin
              r_sub <= r_sub + 1'b1;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign rom_addr   = r_rom_addr;
  assign write_en   = r_we;
  assign write_addr = r_waddr;
  assign write_data = r_we ? rom_data : 16'd0;
  assign frame_idx  = r_frame;
  assign frame_done = r_done;

endmodule
